gate_chip_checker: RTL and testbench

//  Parametrised exhaustive tester for DIP logic chips built from N_GATES identical N_IN-input gates
//  (7400/7402/7408/7420-class parts). It walks every input vector 0..2^N_IN-1 and drives it to all gates at once.

---
 rtl/gate_chip_checker_if.sv | 17 +
 rtl/gate_chip_checker.sv | 151 +++++++++++++++
 tb/tb_gate_chip_checker.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_chip_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_chip_checker_if
// Purpose  : Pin bundle between the gate tester and the chip socket.
// Revision : 1.0
// ============================================================================
interface gate_chip_checker_if #(
    parameter int N_IN    = 4,
    parameter int N_GATES = 2
);
    logic [N_GATES*N_IN-1:0] gate_in;
    logic [N_GATES-1:0]      gate_out;

    modport master (output gate_in, input gate_out);
    modport slave  (input gate_in, output gate_out);
endinterface
`default_nettype wire

// File: rtl/gate_chip_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_chip_checker
// Purpose  : Exhaustive vector sweep of an N_GATES x N_IN-input logic chip,
//            reporting pass/fail, per-gate fail mask and first failing vector.
// Revision : 1.0
// ============================================================================
module gate_chip_checker #(
    parameter int N_IN         = 4,
    parameter int N_GATES      = 2,
    parameter int GATE_FN      = 0,
    parameter int SETTLE_CYC   = 4,
    parameter int STOP_ON_FAIL = 0
) (
    input  wire logic                Clk,
    input  wire logic                Reset,
    input  wire logic                Run,
    input  wire logic                DISP_RSLT,
    gate_chip_checker_if.master      chip,
    output logic                     Done,
    output logic                     RSLT,
    output logic [N_GATES-1:0]       fail_mask,
    output logic [N_IN-1:0]          fail_vec,
    output logic [2:0]               state_o,
    output logic [N_IN-1:0]          input_o
);

    localparam int              c_CNT_W       = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 2);
    localparam bit              c_STOP        = (STOP_ON_FAIL != 0);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_SET    = 3'd1,
        S_DRIVE  = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [N_IN-1:0]           r_vec, w_vec_nxt;
    logic [c_CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [N_GATES-1:0]        r_sync1, r_sync2;
    logic [N_GATES-1:0]        r_fail_mask, w_mask_nxt;
    logic [N_IN-1:0]           r_fail_vec, w_fvec_nxt;
    logic                      r_first_fail, w_first_nxt;
    logic                      r_rslt, w_rslt_nxt;
    logic                      r_done, w_done_nxt;
    logic [N_GATES*N_IN-1:0]   r_gate_in, w_gate_in_nxt;
    logic                      w_exp;
    logic [N_GATES-1:0]        w_mism;

    always_comb begin
        case (GATE_FN)
            1:       w_exp = &r_vec;
            2:       w_exp = ~|r_vec;
            3:       w_exp = |r_vec;
            default: w_exp = ~&r_vec;
        endcase
    end

    assign w_mism = r_sync2 ^ {N_GATES{w_exp}};

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_fail_mask;
        w_fvec_nxt  = r_fail_vec;
        w_first_nxt = r_first_fail;
        w_rslt_nxt  = r_rslt;
        case (r_state)
            S_HALTED: begin
                if (Run) w_state_nxt = S_SET;
            end
            S_SET: begin
                w_vec_nxt   = '0;
                w_mask_nxt  = '0;
                w_fvec_nxt  = '0;
                w_first_nxt = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                if (r_cnt == c_SETTLE_LAST) w_state_nxt = S_SAMPLE;
                else                        w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_SAMPLE: begin
                w_mask_nxt = r_fail_mask | w_mism;
                if ((|w_mism) && !r_first_fail) begin
                    w_fvec_nxt  = r_vec;
                    w_first_nxt = 1'b1;
                end
                // Terminal test precedes the increment so vec never wraps.
                if ((r_vec == '1) || (c_STOP && (|w_mism))) begin
                    w_state_nxt = S_DONE;
                    w_rslt_nxt  = ~|w_mask_nxt;
                end else begin
                    w_vec_nxt   = r_vec + 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DONE: begin
                if (DISP_RSLT) w_state_nxt = S_HALTED;
            end
            default: w_state_nxt = S_HALTED;
        endcase
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_gate_in_nxt = ((w_state_nxt == S_DRIVE) || (w_state_nxt == S_SAMPLE)) ?
                        {N_GATES{w_vec_nxt}} : '0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_HALTED;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_fail_mask  <= '0;
            r_fail_vec   <= '0;
            r_first_fail <= 1'b0;
            r_rslt       <= 1'b0;
            r_done       <= 1'b0;
            r_gate_in    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_vec        <= w_vec_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sync1      <= chip.gate_out;
            r_sync2      <= r_sync1;
            r_fail_mask  <= w_mask_nxt;
            r_fail_vec   <= w_fvec_nxt;
            r_first_fail <= w_first_nxt;
            r_rslt       <= w_rslt_nxt;
            r_done       <= w_done_nxt;
            r_gate_in    <= w_gate_in_nxt;
        end
    end

    assign chip.gate_in = r_gate_in;
    assign Done         = r_done;
    assign RSLT         = r_rslt;
    assign fail_mask    = r_fail_mask;
    assign fail_vec     = r_fail_vec;
    assign state_o      = r_state;
    assign input_o      = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_chip_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_chip_checker
// Purpose  : Scoreboard bench for gate_chip_checker over three configurations.
// Revision : 1.0
// ============================================================================
module tb_gate_chip_checker;

    localparam int c_NI [3] = '{4, 4, 2};
    localparam int c_NG [3] = '{2, 2, 4};
    localparam int c_FN [3] = '{0, 0, 2};
    localparam int c_SC [3] = '{4, 3, 4};
    localparam int c_ST [3] = '{0, 1, 0};

    typedef struct {
        int       k;
        bit       rslt;
        bit [5:0] mask;
        bit [7:0] fv;
        int       lat;
        int       start;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        run  [3];
    logic        disp [3];
    logic        done [3];
    logic        rslt [3];
    logic [5:0]  fmask[3];
    logic [7:0]  fvec [3];
    logic [7:0]  inp  [3];
    logic [2:0]  st   [3];
    logic [31:0] gin  [3];

    // Chip model configuration: actual function, stuck-at-1 gates,
    // gates inverted on one vector, and one registered stage of lag.
    int       model_fn[3];
    bit [5:0] stuck   [3];
    bit [5:0] inv_gm  [3];
    int       inv_vec [3];
    bit       dly     [3];

    exp_t sb_q[$];

    function automatic bit gfn(int fn, int v, int ni);
        int ones = (1 << ni) - 1;
        case (fn)
            1:       return v == ones;
            2:       return v == 0;
            3:       return v != 0;
            default: return v != ones;
        endcase
    endfunction

    function automatic bit chip_val(int mfn, int ni, int v, int g,
                                    bit [5:0] stk, bit [5:0] igm, int iv);
        bit r = gfn(mfn, v, ni);
        if (igm[g] && v == iv) r = !r;
        if (stk[g]) r = 1'b1;
        return r;
    endfunction

    generate
        for (genvar k = 0; k < 3; k++) begin : g_inst
            localparam int NI = c_NI[k];
            localparam int NG = c_NG[k];
            logic [NG-1:0] w_fm, w_comb, r_dly;
            logic [NI-1:0] w_fv, w_inp;

            gate_chip_checker_if #(.N_IN(NI), .N_GATES(NG)) u_if ();

            gate_chip_checker #(
                .N_IN(NI), .N_GATES(NG), .GATE_FN(c_FN[k]),
                .SETTLE_CYC(c_SC[k]), .STOP_ON_FAIL(c_ST[k])
            ) u_dut (
                .Clk(clk), .Reset(rst_n), .Run(run[k]), .DISP_RSLT(disp[k]),
                .chip(u_if.master), .Done(done[k]), .RSLT(rslt[k]),
                .fail_mask(w_fm), .fail_vec(w_fv), .state_o(st[k]), .input_o(w_inp)
            );

            assign fmask[k] = 6'(w_fm);
            assign fvec[k]  = 8'(w_fv);
            assign inp[k]   = 8'(w_inp);
            assign gin[k]   = 32'(u_if.gate_in);

            always_comb begin
                w_comb = '0;
                for (int g = 0; g < NG; g++)
                    w_comb[g] = chip_val(model_fn[k], NI, int'(u_if.gate_in[g*NI +: NI]),
                                         g, stuck[k], inv_gm[k], inv_vec[k]);
            end
            always @(posedge clk) r_dly <= w_comb;
            assign u_if.gate_out = dly[k] ? r_dly : w_comb;
        end
    endgenerate

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk every vector with the chip's steady-state response; a
    // lagging chip on a 3-cycle settle is seen one vector late.
    function automatic exp_t ref_model(int k, int start);
        exp_t     e;
        bit [5:0] m;
        bit       first = 1'b0;
        int       n_vec = 0;
        e.k = k; e.mask = '0; e.fv = '0; e.start = start;
        for (int v = 0; v < (1 << c_NI[k]); v++) begin
            int sv;
            n_vec++;
            sv = (dly[k] && c_SC[k] < 4 && v > 0) ? v - 1 : v;
            m = '0;
            for (int g = 0; g < c_NG[k]; g++)
                m[g] = chip_val(model_fn[k], c_NI[k], sv, g, stuck[k], inv_gm[k], inv_vec[k])
                       ^ gfn(c_FN[k], v, c_NI[k]);
            if (m != 0 && !first) begin
                e.fv  = 8'(v);
                first = 1'b1;
            end
            e.mask |= m;
            if (c_ST[k] != 0 && m != 0) break;
        end
        e.rslt = (e.mask == 0);
        e.lat  = 2 + n_vec * c_SC[k];
        return e;
    endfunction

    task automatic cfg(int k, int mfn, bit [5:0] stk, bit [5:0] igm, int iv, bit d);
        model_fn[k] = mfn; stuck[k] = stk; inv_gm[k] = igm; inv_vec[k] = iv; dly[k] = d;
    endtask

    task automatic push_exp(int k, int start);
        sb_q.push_back(ref_model(k, start));
    endtask

    task automatic start_run(int k, bit push);
        @(negedge clk);
        if (push) push_exp(k, cyc);
        run[k] = 1'b1;
        @(negedge clk);
        run[k] = 1'b0;
    endtask

    task automatic wait_done(int k);
        int n = 0;
        while (!done[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_seen[%0d]", k), 32'(done[k]), 1);
        disp[k] = 1'b1;
        @(negedge clk);
        disp[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("halt_after_ack[%0d]", k), 32'(st[k]), 0);
        chk($sformatf("done_low_after_ack[%0d]", k), 32'(done[k]), 0);
    endtask

    task automatic chk_reset(int k);
        chk($sformatf("rst_state[%0d]", k), 32'(st[k]), 0);
        chk($sformatf("rst_done[%0d]", k), 32'(done[k]), 0);
        chk($sformatf("rst_rslt[%0d]", k), 32'(rslt[k]), 0);
        chk($sformatf("rst_mask[%0d]", k), 32'(fmask[k]), 0);
        chk($sformatf("rst_fvec[%0d]", k), 32'(fvec[k]), 0);
        chk($sformatf("rst_input[%0d]", k), 32'(inp[k]), 0);
        chk($sformatf("rst_gate_in[%0d]", k), gin[k], 0);
    endtask

    // Monitor: pops the scoreboard on every rising Done.
    initial begin
        bit   done_q[3];
        exp_t e;
        for (int k = 0; k < 3; k++) done_q[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done[k] && !done_q[k]) begin
                    if (sb_q.size() == 0) begin
                        chk($sformatf("sb_entry_for_done[%0d]", k), 32'(sb_q.size()), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_instance", k, e.k);
                        chk($sformatf("rslt[%0d]", k), 32'(rslt[k]), 32'(e.rslt));
                        chk($sformatf("fail_mask[%0d]", k), 32'(fmask[k]), 32'(e.mask));
                        chk($sformatf("fail_vec[%0d]", k), 32'(fvec[k]), 32'(e.fv));
                        chk($sformatf("latency[%0d]", k), cyc - e.start, e.lat);
                        chk($sformatf("done_state[%0d]", k), 32'(st[k]), 4);
                        chk($sformatf("done_gate_in[%0d]", k), gin[k], 0);
                    end
                end
                done_q[k] = done[k];
            end
        end
    end

    initial begin
        int n;
        int kk, nik, ngk;
        for (int k = 0; k < 3; k++) begin
            run[k] = 1'b0; disp[k] = 1'b0;
            cfg(k, c_FN[k], '0, '0, -1, 1'b0);
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset(k);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal NAND package
        start_run(0, 1'b1); wait_done(0);
        // Gate 1 stuck high
        cfg(0, 0, 6'b10, '0, -1, 1'b0);
        start_run(0, 1'b1); wait_done(0);
        chk("stuck_mask_held", 32'(fmask[0]), 32'h2);
        chk("stuck_vec_held", 32'(fvec[0]), 32'hF);
        // Early stop: gate 0 wrong on vector 5 only
        cfg(1, 0, '0, 6'b01, 5, 1'b0);
        start_run(1, 1'b1); wait_done(1);
        chk("stop_mask_held", 32'(fmask[1]), 32'h1);
        chk("stop_vec_held", 32'(fvec[1]), 32'h5);
        // NOR package: correct part, then a NAND part in the socket
        start_run(2, 1'b1); wait_done(2);
        cfg(2, 0, '0, '0, -1, 1'b0);
        start_run(2, 1'b1); wait_done(2);
        chk("wrong_part_mask", 32'(fmask[2]), 32'hF);
        chk("wrong_part_vec", 32'(fvec[2]), 32'h1);
        // Lagging chip: too fast a settle fails, the default settle passes
        cfg(1, 0, '0, '0, -1, 1'b1);
        start_run(1, 1'b1); wait_done(1);
        cfg(0, 0, '0, '0, -1, 1'b1);
        start_run(0, 1'b1); wait_done(0);

        // Reset in the middle of a sweep
        cfg(0, 0, '0, 6'b01, 3, 1'b0);
        start_run(0, 1'b0);
        n = 0;
        while (!(inp[0] == 8'd7 && st[0] == 3'd2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec7_drive", 32'(inp[0]), 7);
        #2 rst_n = 1'b0;
        #1 chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg(0, 0, '0, '0, -1, 1'b0);
        start_run(0, 1'b1); wait_done(0);

        // Run and DISP_RSLT together in DONE
        start_run(0, 1'b1);
        n = 0;
        while (!done[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t7_done", 32'(done[0]), 1);
        run[0] = 1'b1; disp[0] = 1'b1;
        @(negedge clk);
        chk("disp_wins", 32'(st[0]), 0);
        push_exp(0, cyc);
        @(negedge clk);
        chk("run_after_halt", 32'(st[0]), 1);
        run[0] = 1'b0; disp[0] = 1'b0;
        wait_done(0);

        // Randomised faults across all configurations
        for (int r = 0; r < 12; r++) begin
            kk  = int'($urandom_range(0, 2));
            nik = c_NI[kk];
            ngk = c_NG[kk];
            cfg(kk,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : c_FN[kk],
                ($urandom_range(0, 3) == 0) ? 6'(1 << $urandom_range(0, ngk - 1)) : 6'd0,
                ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, (1 << ngk) - 1)) : 6'd0,
                int'($urandom_range(0, (1 << nik) - 1)),
                1'($urandom_range(0, 1)));
            start_run(kk, 1'b1);
            wait_done(kk);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
